harmonic_sequencer: RTL and testbench

Frame sequencer for the additive oscillator. Once per sample period it walks harmonics 0..N-1. For each harmonic it handshakes with the sample-position lookup, the multiple scaler and one of NUM_CHANNELS scaling adders. It then latches the adder totals for the DAC output stage. It generalises the fixed two-adder sequencing with these additions:
- parametrised harmonic count and channel count
- runtime harmonic limit
- real comb-mute skipping
- overrun detection

---
 rtl/harmonic_seq_pkg.sv | 20 ++
 rtl/sample_tick_timer.sv | 22 ++
 rtl/harmonic_sequencer.sv | 157 +++++++++++++++
 tb/tb_harmonic_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/harmonic_seq_pkg.sv
// Shared types and constants for the additive-oscillator frame sequencer.
package harmonic_seq_pkg;

  localparam int CLK_HZ              = 48_000_000;
  localparam int SAMPLE_HZ           = 48_000;
  localparam int DEF_SAMPLE_INTERVAL = CLK_HZ / SAMPLE_HZ;

  typedef enum logic [2:0] {
    IDLE, MULT, MULT_WAIT, ADD_START, NEXT, DONE, CLEAR
  } state_e;

  // Bits needed to index n items, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sample_tick_timer.sv
// Free-running sample timer: counts 0..INTERVAL-1 and flags the last count.
module sample_tick_timer #(
  parameter int INTERVAL = 1000,
  parameter int W        = 16
)(
  input  logic i_Clock,
  input  logic i_Reset_n,
  output logic o_Tick
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = (cnt_q == W'(INTERVAL - 1)) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign o_Tick = (cnt_q == W'(INTERVAL - 1));

endmodule

// File: rtl/harmonic_sequencer.sv
// Walks harmonics 0..L-1 once per sample tick, handshaking with the sample
// lookup, multiple scaler and round-robin adders; flags ticks that land mid-frame.
module harmonic_sequencer
  import harmonic_seq_pkg::*;
#(
  parameter int NUM_HARMONICS   = 50,
  parameter int HARM_W          = 8,
  parameter int NUM_CHANNELS    = 2,
  parameter int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL,
  parameter int TIMER_W         = 16
)(
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic [HARM_W-1:0]       i_Harmonic_Limit,
  input  logic                    i_Sample_Ready,
  input  logic                    i_Freq_Too_High,
  input  logic                    i_Mult_Ready,
  input  logic                    i_Comb_Muted,
  output logic [HARM_W-1:0]       o_Harmonic,
  output logic                    o_Next_Sample,
  output logic                    o_Mult_Start,
  output logic                    o_Mult_Restart,
  output logic [NUM_CHANNELS-1:0] o_Adder_Start,
  output logic                    o_Adder_Clear,
  output logic                    o_Latch_Totals,
  output logic                    o_DAC_Send,
  output logic                    o_Overrun,
  output logic [7:0]              o_Overrun_Count,
  output logic                    o_Busy
);

  localparam int CH_W = cnt_width(NUM_CHANNELS);

  state_e                  state_q, state_d;
  logic [HARM_W-1:0]       harm_q, harm_d, lim_q, lim_d, lim_in;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic [7:0]              ovr_cnt_q, ovr_cnt_d;
  logic [NUM_CHANNELS-1:0] add_q, add_d;
  logic ns_q, ns_d, ms_q, ms_d, mr_q, mr_d, clr_q, clr_d, lat_q, lat_d;
  logic dac_q, dac_d, ovr_q, ovr_d, busy_q, busy_d;
  logic tick, last_harm;
  logic [HARM_W:0] harm_inc;

  sample_tick_timer #(.INTERVAL(SAMPLE_INTERVAL), .W(TIMER_W)) u_timer (
    .i_Clock  (i_Clock),
    .i_Reset_n(i_Reset_n),
    .o_Tick   (tick)
  );

  assign lim_in = (i_Harmonic_Limit == '0) ? HARM_W'(1) :
                  (i_Harmonic_Limit > HARM_W'(NUM_HARMONICS)) ? HARM_W'(NUM_HARMONICS) :
                  i_Harmonic_Limit;
  assign harm_inc  = {1'b0, harm_q} + 1'b1;
  assign last_harm = harm_inc >= {1'b0, lim_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tick) state_d = ADD_START;
      MULT:      state_d = MULT_WAIT;
      MULT_WAIT: if (i_Mult_Ready) state_d = i_Comb_Muted ? NEXT : ADD_START;
      ADD_START: if (i_Sample_Ready) state_d = NEXT;
      NEXT:      state_d = (last_harm || i_Freq_Too_High) ? DONE : MULT;
      DONE:      state_d = CLEAR;
      CLEAR:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    harm_d    = harm_q;
    chan_d    = chan_q;
    lim_d     = lim_q;
    ovr_cnt_d = ovr_cnt_q;
    add_d     = '0;
    ns_d      = 1'b0;
    ms_d      = 1'b0;
    mr_d      = 1'b0;
    clr_d     = 1'b0;
    lat_d     = 1'b0;
    ovr_d     = 1'b0;
    dac_d     = tick;
    busy_d    = (state_d != IDLE);
    // A tick mid-frame is dropped; the DAC simply resends the old totals.
    if (tick && state_q != IDLE) begin
      ovr_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
    case (state_q)
      IDLE: if (tick) begin
        ns_d   = 1'b1;
        mr_d   = 1'b1;
        harm_d = '0;
        chan_d = '0;
        lim_d  = lim_in;
      end
      MULT: ms_d = 1'b1;
      ADD_START: if (i_Sample_Ready)
        for (int c = 0; c < NUM_CHANNELS; c++) add_d[c] = (chan_q == CH_W'(c));
      NEXT: if (!(last_harm || i_Freq_Too_High)) begin
        ns_d   = 1'b1;
        harm_d = harm_inc[HARM_W-1:0];
        chan_d = (chan_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : chan_q + 1'b1;
      end
      DONE:    lat_d = 1'b1;
      CLEAR:   clr_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      harm_q    <= '0;
      chan_q    <= '0;
      lim_q     <= HARM_W'(1);
      ovr_cnt_q <= '0;
      add_q     <= '0;
      ns_q      <= 1'b0;
      ms_q      <= 1'b0;
      mr_q      <= 1'b0;
      clr_q     <= 1'b0;
      lat_q     <= 1'b0;
      dac_q     <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      harm_q    <= harm_d;
      chan_q    <= chan_d;
      lim_q     <= lim_d;
      ovr_cnt_q <= ovr_cnt_d;
      add_q     <= add_d;
      ns_q      <= ns_d;
      ms_q      <= ms_d;
      mr_q      <= mr_d;
      clr_q     <= clr_d;
      lat_q     <= lat_d;
      dac_q     <= dac_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign o_Harmonic      = harm_q;
  assign o_Next_Sample   = ns_q;
  assign o_Mult_Start    = ms_q;
  assign o_Mult_Restart  = mr_q;
  assign o_Adder_Start   = add_q;
  assign o_Adder_Clear   = clr_q;
  assign o_Latch_Totals  = lat_q;
  assign o_DAC_Send      = dac_q;
  assign o_Overrun       = ovr_q;
  assign o_Overrun_Count = ovr_cnt_q;
  assign o_Busy          = busy_q;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Randomised bench: each frame is planned as a per-cycle schedule from the
// harmonic walk rules, then DUT outputs are compared against it every cycle.
module tb_harmonic_sequencer;

  localparam int NH = 50, HW = 8, NC = 2, INT = 100, TW = 16;
  localparam int K_IDLE = 0, K_START = 1, K_MULT = 2, K_MWAIT = 3,
                 K_ADD = 4, K_NEXT = 5, K_DONE = 6, K_CLEAR = 7;

  typedef struct { int kind; int h; bit v; bit cm; bit fin; } rec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [HW-1:0] i_Harmonic_Limit = '0;
  logic i_Sample_Ready = 0, i_Freq_Too_High = 0, i_Mult_Ready = 0, i_Comb_Muted = 0;
  logic [HW-1:0] o_Harmonic;
  logic [NC-1:0] o_Adder_Start;
  logic [7:0]    o_Overrun_Count;
  logic o_Next_Sample, o_Mult_Start, o_Mult_Restart, o_Adder_Clear;
  logic o_Latch_Totals, o_DAC_Send, o_Overrun, o_Busy;

  always #5 clk = ~clk;

  harmonic_sequencer #(.NUM_HARMONICS(NH), .HARM_W(HW), .NUM_CHANNELS(NC),
                       .SAMPLE_INTERVAL(INT), .TIMER_W(TW)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Harmonic_Limit(i_Harmonic_Limit),
    .i_Sample_Ready(i_Sample_Ready), .i_Freq_Too_High(i_Freq_Too_High),
    .i_Mult_Ready(i_Mult_Ready), .i_Comb_Muted(i_Comb_Muted),
    .o_Harmonic(o_Harmonic), .o_Next_Sample(o_Next_Sample), .o_Mult_Start(o_Mult_Start),
    .o_Mult_Restart(o_Mult_Restart), .o_Adder_Start(o_Adder_Start),
    .o_Adder_Clear(o_Adder_Clear), .o_Latch_Totals(o_Latch_Totals),
    .o_DAC_Send(o_DAC_Send), .o_Overrun(o_Overrun),
    .o_Overrun_Count(o_Overrun_Count), .o_Busy(o_Busy));

  int passed = 0, total = 0;
  rec_t q[$];
  int tcnt, cyc_rel, mode, dir_limit, frames_done, first_dac;
  int ovr_seen, lat_seen, clr_seen;
  bit rst_armed, rst_now, rst_hit;
  int log_h[$];
  logic [NC-1:0] log_a[$];
  bit e_ns, e_ms, e_mr, e_clr, e_lat, e_dac, e_ovr, e_busy;
  logic [NC-1:0] e_ad;
  int e_harm, e_cnt;
  int plan_mdel[NH], plan_sdel[NH], plan_fth;
  bit plan_mute[NH];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic void push(int k, int h, bit v, bit cm, bit fin);
    q.push_back('{kind:k, h:h, v:v, cm:cm, fin:fin});
  endfunction

  function automatic void zero_exp();
    {e_ns, e_ms, e_mr, e_clr, e_lat, e_dac, e_ovr, e_busy} = '0;
    e_ad = '0; e_harm = 0; e_cnt = 0;
  endfunction

  // Schedule of one frame: which stage each cycle is in and what the
  // peripherals answer, derived from the harmonic walk rules.
  task automatic build_frame(input int lim);
    int L;
    L = (lim == 0) ? 1 : ((lim > NH) ? NH : lim);
    for (int h = 0; h < NH; h++) begin
      plan_mute[h] = 0; plan_mdel[h] = 0; plan_sdel[h] = 0;
    end
    plan_fth = -1;
    case (mode)
      0: begin
        for (int h = 0; h < NH; h++) begin
          plan_mute[h] = ($urandom % 4 == 0);
          plan_mdel[h] = $urandom_range(0, 3);
          plan_sdel[h] = $urandom_range(0, 3);
        end
        plan_fth = ($urandom % 4 == 0) ? int'($urandom_range(0, L - 1)) : -1;
      end
      2: begin plan_mute[3] = 1; plan_mute[6] = 1; end
      3: plan_fth = 2;
      4: for (int h = 0; h < NH; h++) plan_sdel[h] = 5;
      5: plan_mdel[1] = 26000;
      8: plan_mdel[7] = 5;
      default: ;
    endcase
    push(K_START, 0, 0, 0, 0);
    for (int h = 0; h < L; h++) begin
      bit fin;
      if (h > 0) begin
        push(K_MULT, h, 0, 0, 0);
        for (int d = 0; d < plan_mdel[h]; d++) push(K_MWAIT, h, 0, 0, 0);
        push(K_MWAIT, h, 1, plan_mute[h], 0);
      end
      if (h == 0 || !plan_mute[h]) begin
        for (int d = 0; d < plan_sdel[h]; d++) push(K_ADD, h, 0, 0, 0);
        push(K_ADD, h, 1, 0, 0);
      end
      fin = (h + 1 >= L) || (h == plan_fth);
      push(K_NEXT, h, (h == plan_fth), 0, fin);
      if (fin) break;
    end
    push(K_DONE, 0, 0, 0, 0);
    push(K_CLEAR, 0, 0, 0, 0);
  endtask

  // Drive this cycle's inputs and derive the outputs due next cycle.
  task automatic plan_cycle();
    rec_t r;
    bit tick;
    int lim;
    tick = (tcnt == INT - 1);
    lim = (mode == 0) ? (($urandom % 8 == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12)))
                      : dir_limit;
    i_Harmonic_Limit = HW'(lim);
    if (q.size() == 0 && tick) build_frame(lim);
    if (q.size() > 0) r = q.pop_front();
    else r = '{kind:K_IDLE, h:0, v:1'b0, cm:1'b0, fin:1'b0};
    i_Mult_Ready    = 1'($urandom % 2);
    i_Sample_Ready  = 1'($urandom % 2);
    i_Freq_Too_High = ($urandom % 8 == 0);
    i_Comb_Muted    = 1'($urandom % 2);
    case (r.kind)
      K_MWAIT: begin i_Mult_Ready = r.v; if (r.v) i_Comb_Muted = r.cm; end
      K_ADD:   i_Sample_Ready = r.v;
      K_NEXT:  i_Freq_Too_High = r.v;
      default: ;
    endcase
    {e_ns, e_ms, e_mr, e_clr, e_lat} = '0;
    e_ad = '0;
    case (r.kind)
      K_START: begin e_ns = 1; e_mr = 1; e_harm = 0; end
      K_MULT:  e_ms = 1;
      K_ADD:   if (r.v) e_ad = NC'(1) << (r.h % NC);
      K_NEXT:  if (!r.fin) begin e_ns = 1; e_harm = r.h + 1; end
      K_DONE:  e_lat = 1;
      K_CLEAR: begin e_clr = 1; frames_done++; end
      default: ;
    endcase
    e_dac = tick;
    e_ovr = tick && e_busy;
    if (e_ovr && e_cnt < 255) e_cnt++;
    e_busy = (q.size() > 0);
    if (rst_armed && r.kind == K_MWAIT && r.h == 7) rst_now = 1;
  endtask

  task automatic check_outputs();
    chk("harmonic", o_Harmonic, e_harm);
    chk("next_sample", o_Next_Sample, e_ns);
    chk("mult_start", o_Mult_Start, e_ms);
    chk("mult_restart", o_Mult_Restart, e_mr);
    chk("adder_start", o_Adder_Start, e_ad);
    chk("adder_clear", o_Adder_Clear, e_clr);
    chk("latch_totals", o_Latch_Totals, e_lat);
    chk("dac_send", o_DAC_Send, e_dac);
    chk("overrun", o_Overrun, e_ovr);
    chk("overrun_count", o_Overrun_Count, e_cnt);
    chk("busy", o_Busy, e_busy);
    if (o_Adder_Start != '0) begin log_h.push_back(int'(o_Harmonic)); log_a.push_back(o_Adder_Start); end
    if (o_Latch_Totals) lat_seen++;
    if (o_Adder_Clear) clr_seen++;
    if (o_Overrun) ovr_seen++;
    if (o_DAC_Send && first_dac < 0) first_dac = cyc_rel;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    tcnt = 0; cyc_rel = 0; first_dac = -1;
    q.delete();
    zero_exp();
    plan_cycle();
  endtask

  task automatic step();
    @(negedge clk);
    tcnt = (tcnt == INT - 1) ? 0 : tcnt + 1;
    cyc_rel++;
    check_outputs();
    plan_cycle();
    if (rst_now) begin
      rst_now = 0; rst_armed = 0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_harmonic", o_Harmonic, 0);
      chk("async_rst_busy", o_Busy, 0);
      chk("async_rst_pulses", {o_Next_Sample, o_Mult_Start, o_Mult_Restart, o_Adder_Start,
                               o_Adder_Clear, o_Latch_Totals, o_DAC_Send, o_Overrun}, 0);
      repeat (3) @(negedge clk);
      release_reset();
      rst_hit = 1;
    end
  endtask

  task automatic run_frames(input int m, input int lim, input int n);
    int cyc;
    cyc = 0;
    do begin
      while (q.size() > 0 && cyc < 40000) begin step(); cyc++; end
      step(); cyc++;
    end while (q.size() > 0 && cyc < 40000);
    mode = m; dir_limit = lim; frames_done = 0; rst_hit = 0; rst_armed = (m == 8);
    ovr_seen = 0; lat_seen = 0; clr_seen = 0;
    log_h.delete(); log_a.delete();
    cyc = 0;
    while (frames_done < n && !rst_hit && cyc < 40000) begin step(); cyc++; end
    if (cyc >= 40000) begin
      total++;
      $display("FAIL timeout mode %0d: frames %0d of %0d done", m, frames_done, n);
    end
    step();
  endtask

  initial begin
    logic [NC-1:0] pat [5];
    pat = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    mode = 0; dir_limit = 1; tcnt = 0; cyc_rel = 0; first_dac = -1;
    rst_armed = 0; rst_now = 0; rst_hit = 0;
    zero_exp();
    repeat (3) @(negedge clk);
    check_outputs();
    release_reset();

    run_frames(1, 5, 1);
    chk("l5_adder_count", log_a.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("l5_adder_pattern", (i < log_a.size()) ? longint'(log_a[i]) : -1, pat[i]);
      chk("l5_adder_harm", (i < log_h.size()) ? log_h[i] : -1, i);
    end
    chk("l5_latch_count", lat_seen, 1);
    chk("l5_clear_count", clr_seen, 1);

    run_frames(2, 8, 1);
    chk("mute_adder_count", log_a.size(), 6);
    foreach (log_h[i]) begin
      if (log_h[i] == 3 || log_h[i] == 6) chk("mute_no_pulse", log_h[i], -1);
      if (log_h[i] == 4) chk("mute_h4_channel", log_a[i], 2'b01);
    end

    run_frames(3, 50, 1);
    chk("freq_high_adders", log_a.size(), 3);

    run_frames(0, 0, 25);

    run_frames(4, 50, 1);
    chk("overrun_in_frame", ovr_seen, 4);
    chk("overrun_frame_latch", lat_seen, 1);

    run_frames(8, 10, 1);
    chk("reset_taken", rst_hit, 1);

    run_frames(6, 0, 1);
    chk("first_tick_after_reset", first_dac, INT);
    chk("limit0_harmonics", log_a.size(), 1);

    run_frames(7, 200, 1);
    chk("limit200_harmonics", log_a.size(), 50);
    chk("limit200_last_harm", (log_h.size() > 0) ? log_h[log_h.size() - 1] : -1, 49);

    run_frames(0, 0, 10);

    run_frames(5, 2, 1);
    chk("overrun_saturated", o_Overrun_Count, 255);

    run_frames(0, 0, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
